// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Each requester owns a private address window selected by its index in the
// upper address bits. Read data returns after READ_LATENCY cycles, tagged
// with a one-hot id of the requester that issued the read.
module sram_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  localparam int LB_NUM_REQ  = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [ADDR_WIDTH+LB_NUM_REQ-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  output logic                             mem_wr_enable,
  output logic                             mem_rd_enable,
  input  logic [DATA_WIDTH-1:0]            mem_dout,
  output logic                             mem_clk
);

  logic [LB_NUM_REQ-1:0] rr_ptr;
  logic                  grant_any;
  logic [LB_NUM_REQ-1:0] grant_idx;
  logic [LB_NUM_REQ-1:0] cand;

  // Read-return pipeline: valid flags are reset, ids are plain data.
  logic                  vld_p [READ_LATENCY];
  logic [LB_NUM_REQ-1:0] id_p  [READ_LATENCY];

  assign rsp_data = mem_dout;
  assign mem_clk  = clk;

  // Grant search: first valid requester from rr_ptr upward, wrapping. NUM_REQ
  // is a power of two, so the LB_NUM_REQ-bit sum wraps modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + LB_NUM_REQ'(k);
      if (!grant_any && !rst && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Drive the SRAM port and the handshake from the winning requester.
  always_comb begin
    req_ready     = '0;
    mem_addr      = '0;
    mem_din       = '0;
    mem_wr_enable = 1'b0;
    mem_rd_enable = 1'b0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      mem_addr      = {grant_idx, req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH]};
      mem_din       = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      mem_wr_enable = req_write[grant_idx];
      mem_rd_enable = ~req_write[grant_idx];
    end
  end

  // Round-robin pointer: start the next search just past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= grant_idx + 1'b1;
    end
  end

  // Valid flags of the read-return pipeline; reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        vld_p[s] <= 1'b0;
      end
    end else begin
      vld_p[0] <= grant_any & ~req_write[grant_idx];
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  // Requester ids travelling alongside the valid flags.
  always_ff @(posedge clk) begin
    id_p[0] <= grant_idx;
    for (int s = 1; s < READ_LATENCY; s++) begin
      id_p[s] <= id_p[s-1];
    end
  end

  // Tag the returning SRAM word with the id leaving the last stage.
  always_comb begin
    rsp_valid = '0;
    if (!rst && vld_p[READ_LATENCY-1]) begin
      rsp_valid[id_p[READ_LATENCY-1]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: instance A (2 requesters, latency 1) gets
// directed traffic, instance B (4 requesters, latency 3) gets random traffic
// plus a reset while a read is in flight. A transaction-level model checks
// both instances every cycle.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Instance A
  logic        rst_a;
  logic [1:0]  v_a, w_a;
  logic [15:0] addr_a, wd_a;
  logic [1:0]  rdy_a, rv_a;
  logic [7:0]  rsp_a, din_a;
  logic [8:0]  ma_a;
  logic        wr_a, rd_a, mclk_a;
  logic [7:0]  dout_a = 8'h00;
  logic [7:0]  sram_a [512] = '{default: 8'h00};

  // Instance B
  logic        rst_b;
  logic [3:0]  v_b, w_b;
  logic [31:0] addr_b, wd_b;
  logic [3:0]  rdy_b, rv_b;
  logic [7:0]  rsp_b, din_b;
  logic [9:0]  ma_b;
  logic        wr_b, rd_b, mclk_b;
  logic [7:0]  pb [3] = '{default: 8'h00};
  logic [7:0]  sram_b [1024] = '{default: 8'h00};
  logic [3:0]  acc_b = 4'b0;

  sram_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_a (
    .clk(clk), .rst(rst_a), .req_valid(v_a), .req_write(w_a), .req_addr(addr_a),
    .req_wdata(wd_a), .req_ready(rdy_a), .rsp_data(rsp_a), .rsp_valid(rv_a),
    .mem_addr(ma_a), .mem_din(din_a), .mem_wr_enable(wr_a), .mem_rd_enable(rd_a),
    .mem_dout(dout_a), .mem_clk(mclk_a));

  sram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst(rst_b), .req_valid(v_b), .req_write(w_b), .req_addr(addr_b),
    .req_wdata(wd_b), .req_ready(rdy_b), .rsp_data(rsp_b), .rsp_valid(rv_b),
    .mem_addr(ma_b), .mem_din(din_b), .mem_wr_enable(wr_b), .mem_rd_enable(rd_b),
    .mem_dout(pb[2]), .mem_clk(mclk_b));

  // SRAM macro models: synchronous write, read data after 1 / 3 cycles.
  always @(posedge clk) begin
    if (wr_a) sram_a[ma_a] <= din_a;
    dout_a <= sram_a[ma_a];
    if (wr_b) sram_b[ma_b] <= din_b;
    pb[0] <= sram_b[ma_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model state per instance: pointer, expected responses by due cycle,
  // shadow memory, and per-requester waiting time.
  int         m_ptr   [2];
  logic       slot_v  [2][8];
  int         slot_id [2][8];
  logic [7:0] slot_d  [2][8];
  logic [7:0] shadow  [2][1024];
  int         waits   [2][4];

  task automatic model_check(input int inst, input int n, input int lat, input logic r,
                             input logic [31:0] v, w, a, d, rdy, ma, mdin,
                             input logic mwr, mrd, input logic [31:0] rv, rdat);
    int g, c, s, ad;
    logic [31:0] e_rv;
    string p;
    p = $sformatf("inst%0d", inst);
    g = -1;
    ad = 0;
    if (!r) begin
      for (int k = 0; k < n; k++) begin
        c = (m_ptr[inst] + k) % n;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g < 0) begin
      chk({p, " ready"}, rdy, 0);
      chk({p, " mem_addr"}, ma, 0);
      chk({p, " mem_din"}, mdin, 0);
      chk({p, " mem_wr"}, {31'b0, mwr}, 0);
      chk({p, " mem_rd"}, {31'b0, mrd}, 0);
    end else begin
      ad = int'(a[g*8 +: 8]);
      chk({p, " ready"}, rdy, 32'd1 << g);
      chk({p, " mem_addr"}, ma, g * 256 + ad);
      chk({p, " mem_din"}, mdin, {24'b0, d[g*8 +: 8]});
      chk({p, " mem_wr"}, {31'b0, mwr}, {31'b0, w[g]});
      chk({p, " mem_rd"}, {31'b0, mrd}, {31'b0, ~w[g]});
    end
    s = cyc % 8;
    e_rv = (!r && slot_v[inst][s]) ? (32'd1 << slot_id[inst][s]) : 32'd0;
    chk({p, " rsp_valid"}, rv, e_rv);
    if (e_rv != 0) chk({p, " rsp_data"}, rdat, {24'b0, slot_d[inst][s]});
    slot_v[inst][s] = 1'b0;
    for (int q = 0; q < n; q++) begin
      if (r) waits[inst][q] = 0;
      else if (rdy[q]) begin
        chk({p, " wait_within_num_req"}, {31'b0, waits[inst][q] < n}, 1);
        waits[inst][q] = 0;
      end else if (v[q]) waits[inst][q]++;
    end
    if (r) begin
      m_ptr[inst] = 0;
      for (int q = 0; q < 8; q++) slot_v[inst][q] = 1'b0;
    end else if (g >= 0) begin
      m_ptr[inst] = (g + 1) % n;
      if (w[g]) shadow[inst][g*256 + ad] = d[g*8 +: 8];
      else begin
        s = (cyc + lat) % 8;
        slot_v[inst][s]  = 1'b1;
        slot_id[inst][s] = g;
        slot_d[inst][s]  = shadow[inst][g*256 + ad];
      end
    end
  endtask

  // Compare process: check both instances on every falling edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0;
      for (int q = 0; q < 8; q++) begin slot_v[i][q] = 1'b0; slot_id[i][q] = 0; slot_d[i][q] = 8'h00; end
      for (int q = 0; q < 1024; q++) shadow[i][q] = 8'h00;
      for (int q = 0; q < 4; q++) waits[i][q] = 0;
    end
    forever begin
      @(negedge clk);
      model_check(0, 2, 1, rst_a, {30'b0, v_a}, {30'b0, w_a}, {16'b0, addr_a}, {16'b0, wd_a},
                  {30'b0, rdy_a}, {23'b0, ma_a}, {24'b0, din_a}, wr_a, rd_a, {30'b0, rv_a}, {24'b0, rsp_a});
      model_check(1, 4, 3, rst_b, {28'b0, v_b}, {28'b0, w_b}, addr_b, wd_b,
                  {28'b0, rdy_b}, {22'b0, ma_b}, {24'b0, din_b}, wr_b, rd_b, {28'b0, rv_b}, {24'b0, rsp_b});
      acc_b = rdy_b;
      cyc++;
    end
  end

  // Stimulus and literal expectations.
  initial begin
    logic [1:0] prev, expg;
    rst_a = 1'b1; rst_b = 1'b1;
    v_a = 2'b11; w_a = 2'b00; addr_a = '0; wd_a = '0;
    v_b = 4'b0;  w_b = 4'b0;  addr_b = '0; wd_b = '0;

    // Reset held three cycles with both A requesters valid.
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst ready", {30'b0, rdy_a}, 0);
      chk("rst mem_wr", {31'b0, wr_a}, 0);
      chk("rst mem_rd", {31'b0, rd_a}, 0);
      chk("rst rsp_valid", {30'b0, rv_a}, 0);
    end
    rst_a = 1'b0; rst_b = 1'b0; #1;
    chk("first grant after reset", {30'b0, rdy_a}, 32'h1);
    @(posedge clk); #1; v_a = 2'b10; #1;
    chk("second grant after reset", {30'b0, rdy_a}, 32'h2);

    // Requester 1 writes A5 at 0x10, then reads it back.
    @(posedge clk); #1; w_a = 2'b10; addr_a[15:8] = 8'h10; wd_a[15:8] = 8'hA5; #1;
    chk("write mem_addr", {23'b0, ma_a}, 32'h110);
    chk("write mem_wr", {31'b0, wr_a}, 1);
    @(posedge clk); #1; w_a = 2'b00; #1;
    chk("read mem_rd", {31'b0, rd_a}, 1);
    chk("read mem_addr", {23'b0, ma_a}, 32'h110);
    @(posedge clk); #1; v_a = 2'b00; #1;
    chk("read rsp_valid", {30'b0, rv_a}, 32'h2);
    chk("read rsp_data", {24'b0, rsp_a}, 32'hA5);

    // Contention: both read every cycle; grants alternate.
    addr_a[7:0] = 8'h20;
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1; v_a = 2'b11; #1;
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("contention grant", {30'b0, rdy_a}, {30'b0, expg});
      if (k > 0) begin
        chk("contention rsp_valid", {30'b0, rv_a}, {30'b0, prev});
        chk("contention rsp_data", {24'b0, rsp_a}, (prev == 2'b10) ? 32'hA5 : 32'h00);
      end
      prev = expg;
    end
    @(posedge clk); #1; v_a = 2'b01; #1;
    chk("contention tail grant", {30'b0, rdy_a}, 32'h1);
    chk("contention tail rsp", {30'b0, rv_a}, 32'h2);
    @(posedge clk); #1; v_a = 2'b00; #1;
    chk("contention last rsp", {30'b0, rv_a}, 32'h1);
    chk("contention last data", {24'b0, rsp_a}, 32'h00);

    // Isolation: same local address 0x00 in both windows.
    @(posedge clk); #1; v_a = 2'b01; w_a = 2'b01; addr_a = 16'h0000; wd_a = 16'hC33C; #1;
    chk("iso w0 mem_addr", {23'b0, ma_a}, 32'h000);
    chk("iso w0 din", {24'b0, din_a}, 32'h3C);
    @(posedge clk); #1; v_a = 2'b10; w_a = 2'b10; #1;
    chk("iso w1 mem_addr", {23'b0, ma_a}, 32'h100);
    chk("iso w1 din", {24'b0, din_a}, 32'hC3);
    @(posedge clk); #1; v_a = 2'b01; w_a = 2'b00; #1;
    chk("iso r0 mem_addr", {23'b0, ma_a}, 32'h000);
    @(posedge clk); #1; v_a = 2'b10; #1;
    chk("iso r1 mem_addr", {23'b0, ma_a}, 32'h100);
    chk("iso r0 rsp_valid", {30'b0, rv_a}, 32'h1);
    chk("iso r0 rsp_data", {24'b0, rsp_a}, 32'h3C);
    @(posedge clk); #1; v_a = 2'b00; #1;
    chk("iso r1 rsp_valid", {30'b0, rv_a}, 32'h2);
    chk("iso r1 rsp_data", {24'b0, rsp_a}, 32'hC3);

    // Random mixed traffic on B; each request held until granted.
    for (int t = 0; t < 10000; t++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        if (v_b[c] && acc_b[c]) v_b[c] = 1'b0;
        if (!v_b[c] && $urandom_range(0, 9) < 6) begin
          v_b[c] = 1'b1;
          w_b[c] = ($urandom_range(0, 1) == 1);
          addr_b[c*8 +: 8] = 8'($urandom_range(0, 15));
          wd_b[c*8 +: 8]   = 8'($urandom);
        end
      end
    end
    repeat (20) begin @(posedge clk); #1; v_b = v_b & ~acc_b; end
    v_b = 4'b0;
    repeat (6) @(posedge clk);

    // Reset while a requester-2 read is in flight.
    #1; v_b = 4'b0100; w_b = 4'b0000; addr_b[23:16] = 8'h05; #1;
    chk("midflight grant", {28'b0, rdy_b}, 32'h4);
    chk("midflight mem_rd", {31'b0, rd_b}, 1);
    @(posedge clk); #1; v_b = 4'b0000; rst_b = 1'b1; #1;
    chk("midflight rsp in reset", {28'b0, rv_b}, 0);
    @(posedge clk); #1; rst_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1; chk("midflight no rsp", {28'b0, rv_b}, 0);
      @(posedge clk); #1;
    end
    v_b = 4'b1001; #1;
    chk("pointer zero after reset", {28'b0, rdy_b}, 32'h1);
    @(posedge clk); #1; v_b = 4'b1000; #1;
    chk("pointer advance", {28'b0, rdy_b}, 32'h8);
    @(posedge clk); #1; v_b = 4'b0000;
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
